// File: rtl/mtime_timer_unit.sv
// Machine timer and software-interrupt responder: 64-bit mtime with prescaler,
// 64-bit mtimecmp, msip bit, and a two-state (IDLE/RESP) bus handshake.
`timescale 1ns/1ps
module mtime_timer_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  input  logic        ren,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        timer_int,
  output logic        soft_int,
  output logic        dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  localparam logic [15:0] PRE_MAX   = 16'(PRESCALE - 1);
  localparam logic [13:0] W_MSIP    = 14'h0000;
  localparam logic [13:0] W_CMP_LO  = 14'h1000;
  localparam logic [13:0] W_CMP_HI  = 14'h1001;
  localparam logic [13:0] W_MT_LO   = 14'h2FFE;
  localparam logic [13:0] W_MT_HI   = 14'h2FFF;

  state_t      r_state;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic [15:0] r_pre_cnt;
  logic        r_timer_int;
  logic        r_soft_int;
  logic [31:0] r_rdata;

  logic [31:0] w_off;
  logic [13:0] w_word;
  logic        w_unused_bits;
  logic        w_req;
  logic        w_wr;
  logic        w_rd;
  logic        w_rw_both;
  logic        w_tick;
  logic        w_mt_lo_wr;
  logic        w_mt_hi_wr;
  logic [31:0] w_rd_data;

  // Decode is relative to BASE_ADDR inside the 64 KiB window; byte offset bits are don't-care.
  assign w_off         = addr - BASE_ADDR;
  assign w_word        = w_off[15:2];
  assign w_unused_bits = ^{w_off[31:16], w_off[1:0]};

  // Handshake: requester holds a request until it sees busy=0; IDLE samples it
  // (busy=1), RESP is the one-cycle ack/data phase (busy=0) and ignores inputs.
  assign w_req     = (r_state == S_IDLE) && (ren || wen);
  assign w_wr      = w_req && wen;
  assign w_rd      = w_req && ren && !wen;
  assign w_rw_both = w_req && ren && wen;
  assign w_tick    = (r_pre_cnt == PRE_MAX);
  assign w_mt_lo_wr = w_wr && (w_word == W_MT_LO);
  assign w_mt_hi_wr = w_wr && (w_word == W_MT_HI);

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    w_rd_data = 32'h0;
    case (w_word)
      W_MSIP:   w_rd_data = {31'h0, r_msip};
      W_CMP_LO: w_rd_data = r_mtimecmp[31:0];
      W_CMP_HI: w_rd_data = r_mtimecmp[63:32];
      W_MT_LO:  w_rd_data = r_mtime[31:0];
      W_MT_HI:  w_rd_data = r_mtime[63:32];
      default:  w_rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) r_state <= S_RESP;
          if (w_rd) r_rdata <= w_rd_data;
          else if (w_rw_both) r_rdata <= 32'h0;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A bus write to either mtime half wins over the tick; the prescaler keeps running.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_mtime     <= 64'h0;
      r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip      <= 1'b0;
      r_pre_cnt   <= 16'h0;
      r_timer_int <= 1'b0;
      r_soft_int  <= 1'b0;
    end else begin
      r_pre_cnt   <= w_tick ? 16'h0 : r_pre_cnt + 16'd1;
      r_timer_int <= (r_mtime >= r_mtimecmp);
      r_soft_int  <= r_msip;
      if (w_mt_lo_wr) r_mtime[31:0] <= merge_lanes(r_mtime[31:0], wdata, byte_en);
      else if (w_mt_hi_wr) r_mtime[63:32] <= merge_lanes(r_mtime[63:32], wdata, byte_en);
      else if (w_tick) r_mtime <= r_mtime + 64'd1;
      if (w_wr && (w_word == W_CMP_LO))
        r_mtimecmp[31:0] <= merge_lanes(r_mtimecmp[31:0], wdata, byte_en);
      if (w_wr && (w_word == W_CMP_HI))
        r_mtimecmp[63:32] <= merge_lanes(r_mtimecmp[63:32], wdata, byte_en);
      if (w_wr && (w_word == W_MSIP) && byte_en[0]) r_msip <= wdata[0];
    end
  end

  assign busy      = w_req;
  assign rdata     = r_rdata;
  assign timer_int = r_timer_int;
  assign soft_int  = r_soft_int;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mtime_timer_unit.sv
// Bench for mtime_timer_unit: two instances (PRESCALE 1 and 4) checked against a
// register-level model that advances mtime from the prescale rule each clock.
`timescale 1ns/1ps
module tb_mtime_timer_unit;
  localparam logic [31:0] BASE0 = 32'h0200_0000;
  localparam logic [31:0] BASE1 = 32'h1000_0000;
  localparam int PRE0 = 1;
  localparam int PRE1 = 4;

  logic        CLK, nRST;
  logic [31:0] addr_a[2], wdata_a[2], rdata_a[2];
  logic [3:0]  be_a[2];
  logic        ren_a[2], wen_a[2], busy_a[2], tint_a[2], sint_a[2], dbg_a[2];

  logic        wr_pend[2];
  logic [63:0] m_mtime[2], m_cmp[2];
  logic        m_msip[2], m_tint[2], m_sint[2];
  int          m_pre[2];
  logic [31:0] m_rd[2];
  int          checks, errors;

  mtime_timer_unit #(.BASE_ADDR(BASE0), .PRESCALE(PRE0)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .addr(addr_a[0]), .wdata(wdata_a[0]), .byte_en(be_a[0]),
    .ren(ren_a[0]), .wen(wen_a[0]), .rdata(rdata_a[0]), .busy(busy_a[0]),
    .timer_int(tint_a[0]), .soft_int(sint_a[0]), .dbg_state(dbg_a[0]));

  mtime_timer_unit #(.BASE_ADDR(BASE1), .PRESCALE(PRE1)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .addr(addr_a[1]), .wdata(wdata_a[1]), .byte_en(be_a[1]),
    .ren(ren_a[1]), .wen(wen_a[1]), .rdata(rdata_a[1]), .busy(busy_a[1]),
    .timer_int(tint_a[1]), .soft_int(sint_a[1]), .dbg_state(dbg_a[1]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int pre_of(input int k);
    return (k == 0) ? PRE0 : PRE1;
  endfunction

  function automatic logic [15:0] word_off(input int k);
    logic [31:0] d;
    d = addr_a[k] - base_of(k);
    return d[15:0] & 16'hFFFC;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    return res;
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [15:0] off);
    case (off & 16'hFFFC)
      16'h0000: return {31'h0, m_msip[k]};
      16'h4000: return m_cmp[k][31:0];
      16'h4004: return m_cmp[k][63:32];
      16'hBFF8: return m_mtime[k][31:0];
      16'hBFFC: return m_mtime[k][63:32];
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic [15:0] pick_off(input int sel);
    case (sel)
      0: return 16'h0000;  1: return 16'h4000;  2: return 16'h4004;
      3: return 16'hBFF8;  4: return 16'hBFFC;  5: return 16'h0004;
      6: return 16'h4008;  7: return 16'h8000;  8: return 16'hFFFC;
      default: return 16'hBFF8;
    endcase
  endfunction

  // Reference model: register contents after each clock edge.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < 2; k++) begin
        m_mtime[k] <= 64'h0;
        m_cmp[k]   <= 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip[k]  <= 1'b0;
        m_pre[k]   <= 0;
        m_tint[k]  <= 1'b0;
        m_sint[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_tint[k] <= (m_mtime[k] >= m_cmp[k]);
        m_sint[k] <= m_msip[k];
        m_pre[k]  <= (m_pre[k] == pre_of(k) - 1) ? 0 : m_pre[k] + 1;
        if (wr_pend[k]) begin
          case (word_off(k))
            16'h0000: if (be_a[k][0]) m_msip[k] <= wdata_a[k][0];
            16'h4000: m_cmp[k][31:0]    <= lanes(m_cmp[k][31:0], wdata_a[k], be_a[k]);
            16'h4004: m_cmp[k][63:32]   <= lanes(m_cmp[k][63:32], wdata_a[k], be_a[k]);
            16'hBFF8: m_mtime[k][31:0]  <= lanes(m_mtime[k][31:0], wdata_a[k], be_a[k]);
            16'hBFFC: m_mtime[k][63:32] <= lanes(m_mtime[k][63:32], wdata_a[k], be_a[k]);
            default: ;
          endcase
        end
        if (!(wr_pend[k] && (word_off(k) == 16'hBFF8 || word_off(k) == 16'hBFFC)) &&
            (m_pre[k] == pre_of(k) - 1))
          m_mtime[k] <= m_mtime[k] + 64'd1;
      end
    end
  end

  task automatic wait_cycles(input int k, input int n);
    repeat (n) begin
      @(negedge CLK);
      checks++;
      if (tint_a[k] !== m_tint[k]) begin
        errors++;
        $display("FAIL timer_int[%0d] t=%0t: got %b expected %b", k, $time, tint_a[k], m_tint[k]);
      end
      checks++;
      if (sint_a[k] !== m_sint[k]) begin
        errors++;
        $display("FAIL soft_int[%0d] t=%0t: got %b expected %b", k, $time, sint_a[k], m_sint[k]);
      end
    end
  endtask

  // Starts right after a falling edge; returns at the falling edge of the cycle after RESP.
  task automatic access(input int k, input logic [15:0] off, input logic [31:0] wd,
                        input logic [3:0] be, input logic r, input logic w,
                        output logic [31:0] rd);
    logic [31:0] exp_rd;
    addr_a[k] = base_of(k) + {16'h0, off};
    wdata_a[k] = wd;
    be_a[k] = be;
    ren_a[k] = r;
    wen_a[k] = w;
    wr_pend[k] = w;
    exp_rd = w ? 32'h0 : model_read(k, off);
    if (r) m_rd[k] = exp_rd;
    #1;
    checks++;
    if (busy_a[k] !== 1'b1) begin
      errors++;
      $display("FAIL busy_req[%0d] off=%h: got %b expected 1", k, off, busy_a[k]);
    end
    @(posedge CLK);
    @(negedge CLK);
    wr_pend[k] = 1'b0;
    checks++;
    if (busy_a[k] !== 1'b0 || dbg_a[k] !== 1'b1) begin
      errors++;
      $display("FAIL resp_phase[%0d]: got busy=%b state=%b expected busy=0 state=1", k, busy_a[k], dbg_a[k]);
    end
    checks++;
    if (rdata_a[k] !== m_rd[k]) begin
      errors++;
      $display("FAIL rdata[%0d] off=%h r=%b w=%b: got %h expected %h", k, off, r, w, rdata_a[k], m_rd[k]);
    end
    checks++;
    if (tint_a[k] !== m_tint[k] || sint_a[k] !== m_sint[k]) begin
      errors++;
      $display("FAIL irq_resp[%0d]: got t=%b s=%b expected t=%b s=%b", k, tint_a[k], sint_a[k], m_tint[k], m_sint[k]);
    end
    rd = rdata_a[k];
    ren_a[k] = 1'b0;
    wen_a[k] = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      addr_a[k] = base_of(k); wdata_a[k] = '0; be_a[k] = '0;
      ren_a[k] = 1'b0; wen_a[k] = 1'b0; wr_pend[k] = 1'b0; m_rd[k] = '0;
    end
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (tint_a[k] !== 1'b0 || sint_a[k] !== 1'b0 || rdata_a[k] !== 32'h0 ||
          busy_a[k] !== 1'b0 || dbg_a[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got t=%b s=%b rd=%h busy=%b st=%b expected all 0",
                 k, tint_a[k], sint_a[k], rdata_a[k], busy_a[k], dbg_a[k]);
      end
    end
    ren_a[0] = 1'b1;
    #1;
    checks++;
    if (busy_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy_comb: got %b expected 1", busy_a[0]);
    end
    ren_a[0] = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_read_mtime();
    logic [31:0] rd;
    wait_cycles(0, 5);
    access(0, 16'hBFF8, 32'h0, 4'h0, 1'b1, 1'b0, rd);
    checks++;
    if (rd !== 32'd5) begin
      errors++;
      $display("FAIL mtime_after_reset: got %0d expected 5", rd);
    end
  endtask

  task automatic test_compare();
    logic [31:0] rd;
    access(0, 16'hBFF8, 32'h0, 4'hF, 1'b0, 1'b1, rd);
    access(0, 16'h4000, 32'h20, 4'hF, 1'b0, 1'b1, rd);
    access(0, 16'h4004, 32'h0, 4'hF, 1'b0, 1'b1, rd);
    wait_cycles(0, 40);
    checks++;
    if (tint_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL cmp_reached: got %b expected 1", tint_a[0]);
    end
  endtask

  task automatic test_cmp_raise();
    logic [31:0] rd;
    access(0, 16'h4004, 32'h1, 4'hF, 1'b0, 1'b1, rd);
    wait_cycles(0, 3);
    checks++;
    if (tint_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL cmp_raised: got %b expected 0", tint_a[0]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    access(0, 16'h4000, 32'h0, 4'hF, 1'b0, 1'b1, rd);
    access(0, 16'h4004, 32'h0, 4'hF, 1'b0, 1'b1, rd);
    access(0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, rd);
    access(0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, rd);
    access(0, 16'hBFFC, 32'h0, 4'h0, 1'b1, 1'b0, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL wrap_high: got %h expected 0", rd);
    end
    access(0, 16'hBFF8, 32'h0, 4'h0, 1'b1, 1'b0, rd);
    wait_cycles(0, 2);
    checks++;
    if (tint_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_timer_int: got %b expected 1", tint_a[0]);
    end
  endtask

  task automatic test_soft();
    logic [31:0] rd;
    access(0, 16'h0000, 32'h1, 4'b0001, 1'b0, 1'b1, rd);
    checks++;
    if (sint_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL msip_set: got %b expected 1", sint_a[0]);
    end
    access(0, 16'h0000, 32'h0, 4'b0000, 1'b0, 1'b1, rd);
    wait_cycles(0, 2);
    checks++;
    if (sint_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL msip_be0_hold: got %b expected 1", sint_a[0]);
    end
    access(0, 16'h0000, 32'h0, 4'b0001, 1'b0, 1'b1, rd);
    wait_cycles(0, 2);
    checks++;
    if (sint_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL msip_clear: got %b expected 0", sint_a[0]);
    end
  endtask

  task automatic test_prescale4();
    logic [31:0] r1, r2, r3;
    access(1, 16'hBFF8, 32'h0, 4'h0, 1'b1, 1'b0, r1);
    wait_cycles(1, $urandom_range(0, 3));
    access(1, 16'hBFF8, 32'h0, 4'h0, 1'b1, 1'b0, r1);
    for (int i = 0; i < 8 && m_pre[1] != PRE1 - 1; i++) @(negedge CLK);
    access(1, 16'hBFF8, 32'd100, 4'hF, 1'b0, 1'b1, r1);
    access(1, 16'hBFF8, 32'h0, 4'h0, 1'b1, 1'b0, r1);
    access(1, 16'hBFF8, 32'h0, 4'h0, 1'b1, 1'b0, r2);
    access(1, 16'hBFF8, 32'h0, 4'h0, 1'b1, 1'b0, r3);
    checks++;
    if (r1 !== 32'd100 || r3 !== 32'd101) begin
      errors++;
      $display("FAIL prescale_write_tick: got %0d,%0d expected 100,101", r1, r3);
    end
  endtask

  task automatic test_rw_both();
    logic [31:0] rd, v;
    v = $urandom;
    access(0, 16'h4000, v, 4'hF, 1'b1, 1'b1, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL rw_both_rdata: got %h expected 0", rd);
    end
    access(0, 16'h4000, 32'h0, 4'h0, 1'b1, 1'b0, rd);
    checks++;
    if (rd !== v) begin
      errors++;
      $display("FAIL rw_both_write: got %h expected %h", rd, v);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    int k, op;
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 1);
      op = $urandom_range(0, 3);
      access(k, pick_off($urandom_range(0, 9)) | 16'($urandom_range(0, 3)), $urandom,
             4'($urandom_range(0, 15)), op != 2, op >= 2, rd);
      wait_cycles(k, $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev, rd;
    access(0, 16'hBFF8, 32'h0, 4'h0, 1'b1, 1'b0, prev);
    for (int i = 0; i < 5; i++) begin
      access(0, 16'hBFF8, 32'h0, 4'h0, 1'b1, 1'b0, rd);
      checks++;
      if (rd !== prev + 32'd2) begin
        errors++;
        $display("FAIL back_to_back #%0d: got %h expected %h", i, rd, prev + 32'd2);
      end
      prev = rd;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] lo, hi;
    addr_a[0] = BASE0 + 32'h4000; wdata_a[0] = 32'h0; be_a[0] = 4'hF; wen_a[0] = 1'b1;
    #1;
    checks++;
    if (busy_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before: got %b expected 1", busy_a[0]);
    end
    #1 nRST = 1'b0;
    #1;
    checks++;
    if (dbg_a[0] !== 1'b0 || rdata_a[0] !== 32'h0 || tint_a[0] !== 1'b0 || sint_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: got st=%b rd=%h t=%b s=%b expected 0", dbg_a[0], rdata_a[0], tint_a[0], sint_a[0]);
    end
    wen_a[0] = 1'b0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    #1;
    checks++;
    if (busy_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy_after: got %b expected 0", busy_a[0]);
    end
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    access(0, 16'h4000, 32'h0, 4'h0, 1'b1, 1'b0, lo);
    access(0, 16'h4004, 32'h0, 4'h0, 1'b1, 1'b0, hi);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL mid_reset_cmp: got %h expected ffffffffffffffff", {hi, lo});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read_mtime();
    test_compare();
    test_cmp_raise();
    test_wrap();
    test_soft();
    test_prescale4();
    test_rw_both();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
